digit_serial_subtract: RTL and testbench



---
 rtl/fixed_point_pkg.sv | 16 +
 rtl/digit_subtract_slice.sv | 27 ++
 rtl/digit_serial_subtract.sv | 117 +++++++++++
 tb/tb_digit_serial_subtract.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and sizing helpers for the digit-serial fixed-point units.
package fixed_point_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Number of digit slices in one operand.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // The counter is kept at least one bit wide so that DIGIT == WIDTH still elaborates.
  function automatic int digit_cnt_width(input int width, input int digit);
    return (width / digit > 1) ? $clog2(width / digit) : 1;
  endfunction

endpackage

// File: rtl/digit_subtract_slice.sv
// One DIGIT-wide ripple slice of a + ~b + cin. The caller supplies b already inverted.
module digit_subtract_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b_inv,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic [DIGIT-1:0] prop,
  output logic [DIGIT-1:0] gen
);

  logic [DIGIT:0] c;

  assign prop = a ^ b_inv;
  assign gen  = a & b_inv;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) c[i+1] = gen[i] | (prop[i] & c[i]);
  end

  assign sum  = prop ^ c[DIGIT-1:0];
  assign cout = c[DIGIT];

endmodule

// File: rtl/digit_serial_subtract.sv
// Digit-serial subtractor d = a - b, DIGIT bits per cycle, LS digit first.
// Define DIGIT_SERIAL_SUBTRACT_SAT_EN to saturate d on signed overflow.
module digit_serial_subtract
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = digit_cnt_width(WIDTH, DIGIT);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_subtract: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [WIDTH-1:0]  a_sh, nb_sh, res_sh, res_nx, d_fin;
  logic              sign_a, sign_b;
  logic [DIGIT-1:0]  sum, prop, gen;
  logic              cout, last, ovf_nx;
  logic              slice_unused;

  digit_subtract_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b_inv (nb_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (sum),
    .cout  (cout),
    .prop  (prop),
    .gen   (gen)
  );

  // Propagate/generate are exported for a lookahead variant; the ripple carry suffices here.
  assign slice_unused = ^{prop, gen};

  assign last   = (cnt == CW'(N - 1));
  assign res_nx = (WIDTH'(sum) << (WIDTH - DIGIT)) | (res_sh >> DIGIT);
  // On the last digit res_nx is the full difference, so its MSB is sign(d).
  assign ovf_nx = (sign_a != sign_b) && (res_nx[WIDTH-1] != sign_a);

`ifdef DIGIT_SERIAL_SUBTRACT_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  assign d_fin = ovf_nx ? (sign_a ? SMIN : ~SMIN) : res_nx;
`else
  assign d_fin = res_nx;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b1;
      a_sh   <= '0;
      nb_sh  <= '0;
      res_sh <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          nb_sh  <= ~b;
          carry  <= 1'b1;
          cnt    <= '0;
          sign_a <= a[WIDTH-1];
          sign_b <= b[WIDTH-1];
        end
        BUSY: begin
          a_sh   <= a_sh >> DIGIT;
          nb_sh  <= nb_sh >> DIGIT;
          res_sh <= res_nx;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            d      <= d_fin;
            borrow <= ~cout;
            ovf    <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_subtract.sv
// Randomized self-checking bench for digit_serial_subtract (WIDTH=8, DIGIT=2).
module tb_digit_serial_subtract;

  localparam int W   = 8;
  localparam int DG  = 2;
  localparam int LAT = W / DG;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, d;
  logic         borrow, ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rdy_mode = 1;  // 0: low, 1: high, 2: random

  digit_serial_subtract #(.WIDTH(W), .DIGIT(DG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] dd, output logic br, output logic ov);
    int diff;
    diff = int'($signed(x)) - int'($signed(y));
    dd = x - y;
    br = (x < y);
    ov = (diff > 127) || (diff < -128);
`ifdef DIGIT_SERIAL_SUBTRACT_SAT_EN
    if (ov) dd = (diff > 127) ? 8'h7F : 8'h80;
`endif
  endtask

  // Model state: one operation in flight, plus the last completed result.
  bit         armed = 0, pending = 0, done_exp;
  int         acc = 0;
  logic [7:0] nd, ld;
  logic       nb, no, lb, lo;

  initial begin
    ld = '0; lb = 1'b0; lo = 1'b0; nd = '0; nb = 1'b0; no = 1'b0;
  end

  always @(negedge clk) begin
    if (armed) begin
      done_exp = pending && (cyc - acc >= LAT);
      chk1("in_ready", in_ready, !pending);
      chk1("out_valid", out_valid, done_exp);
      chk8("d", d, done_exp ? nd : ld);
      chk1("borrow", borrow, done_exp ? nb : lb);
      chk1("ovf", ovf, done_exp ? no : lo);
    end
    if (rst) begin
      pending = 0; ld = '0; lb = 1'b0; lo = 1'b0; armed = 1;
    end else if (armed) begin
      if (pending && done_exp && out_ready) begin
        pending = 0; ld = nd; lb = nb; lo = no;
      end else if (!pending && in_valid) begin
        pending = 1; acc = cyc + 1;
        model(a, b, nd, nb, no);
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic do_op(input logic [7:0] x, input logic [7:0] y);
    bit got = 0;
    a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    chk1("accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] rd, output logic rb, output logic ro, output int lat);
    bit got = 0;
    lat = 0; rd = 'x; rb = 1'bx; ro = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        rd = d; rb = borrow; ro = ovf; got = 1; break;
      end
      if (!out_valid) lat++;
    end
    chk1("done_timeout", got, 1'b1);
  endtask

  logic [7:0] rd, md;
  logic       rb, ro, mb, mo;
  int         lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

    // Pin the model itself against hand-computed values.
    model(8'h05, 8'h03, md, mb, mo);
    chk8("pin_d_05_03", md, 8'h02); chk1("pin_b_05_03", mb, 1'b0); chk1("pin_o_05_03", mo, 1'b0);
    model(8'h80, 8'h01, md, mb, mo);
    chk1("pin_o_80_01", mo, 1'b1); chk1("pin_b_80_01", mb, 1'b0);
    model(8'h7F, 8'hFF, md, mb, mo);
    chk1("pin_o_7F_FF", mo, 1'b1); chk1("pin_b_7F_FF", mb, 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk8("reset_d", d, 8'h00);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);

    rdy_mode = 1;
    @(posedge clk); #1;
    do_op(8'h05, 8'h03); wait_done(rd, rb, ro, lat);
    chk8("lat_05_03", 8'(lat), 8'(LAT));
    chk8("d_05_03", rd, 8'h02); chk1("b_05_03", rb, 1'b0); chk1("o_05_03", ro, 1'b0);

    do_op(8'h03, 8'h05); wait_done(rd, rb, ro, lat);
    chk8("d_03_05", rd, 8'hFE); chk1("b_03_05", rb, 1'b1); chk1("o_03_05", ro, 1'b0);

    do_op(8'h80, 8'h01); wait_done(rd, rb, ro, lat);
`ifdef DIGIT_SERIAL_SUBTRACT_SAT_EN
    chk8("d_80_01", rd, 8'h80);
`else
    chk8("d_80_01", rd, 8'h7F);
`endif
    chk1("b_80_01", rb, 1'b0); chk1("o_80_01", ro, 1'b1);

    do_op(8'h7F, 8'hFF); wait_done(rd, rb, ro, lat);
`ifdef DIGIT_SERIAL_SUBTRACT_SAT_EN
    chk8("d_7F_FF", rd, 8'h7F);
`else
    chk8("d_7F_FF", rd, 8'h80);
`endif
    chk1("b_7F_FF", rb, 1'b1); chk1("o_7F_FF", ro, 1'b1);

    // Backpressure with a competing request held on the input.
    rdy_mode = 0;
    @(posedge clk); #1;
    do_op(8'h80, 8'h01);
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
`ifdef DIGIT_SERIAL_SUBTRACT_SAT_EN
      chk8("bp_d", d, 8'h80);
`else
      chk8("bp_d", d, 8'h7F);
`endif
      chk1("bp_ovf", ovf, 1'b1);
    end
    rdy_mode = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("bp_release_valid", out_valid, 1'b1);
    @(negedge clk);
    chk1("bp_idle_in_ready", in_ready, 1'b1);
    chk1("bp_idle_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(rd, rb, ro, lat);
    chk8("d_11_22", rd, 8'hEF); chk1("b_11_22", rb, 1'b1); chk1("o_11_22", ro, 1'b0);

    // Reset during the second BUSY cycle abandons the operation.
    do_op(8'h10, 8'h01);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk1("rst_mid_in_ready", in_ready, 1'b1);
    chk8("rst_mid_d", d, 8'h00);
    @(posedge clk); #1;
    do_op(8'h10, 8'h01); wait_done(rd, rb, ro, lat);
    chk8("d_10_01", rd, 8'h0F); chk1("b_10_01", rb, 1'b0); chk1("o_10_01", ro, 1'b0);

    // Random traffic with random backpressure; requests overlap busy periods.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] x, y;
      case ($urandom_range(0, 4))
        0: x = 8'h80; 1: x = 8'h7F; default: x = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: y = 8'hFF; 1: y = 8'h01; default: y = 8'($urandom);
      endcase
      do_op(x, y);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    begin
      bit idle = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (in_ready && !pending) begin idle = 1; break; end
      end
      chk1("drain_timeout", idle, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
